angle_pair_scheduler: RTL and testbench
=======================================

ANGLE_PAIR_SCHEDULER -- requirements
Module: angle_pair_scheduler

Interface
REQ-001 Parameter NUM_PAIRS, default 4: number of microphone-pair requesters sharing one angle engine.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles allowed in ISSUE before the job is aborted.
REQ-003 Parameter GAP, default 2: idle cycles with eng_ena low between consecutive engine jobs.
REQ-004 clk_60MHz  in  1  sole clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_PAIRS  level request per pair; held until ack.
REQ-007 lag_in  in  6*NUM_PAIRS  signed lag per pair; pair i occupies bits [6i+5:6i].
REQ-008 ack  out  NUM_PAIRS  one-hot, one-cycle pulse that closes the granted pair's job.
REQ-009 eng_ena  out  1  enable to the shared angle engine.
REQ-010 eng_lag  out  6  signed lag presented to the engine.
REQ-011 eng_angle  in  16  engine result; valid when eng_done=1.
REQ-012 eng_done  in  1  engine completion pulse.
REQ-013 angle_out  out  16  registered result of the last successful job.
REQ-014 angle_valid  out  1  one-cycle pulse; angle_out and angle_id are valid.
REQ-015 angle_id  out  2  index of the pair that owns angle_out.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 timeout_err  out  1  one-cycle pulse on an aborted job; angle_id carries the pair index.

Function
REQ-018 FSM states: IDLE, ISSUE, RESULT, GAP; one-hot or binary encoding is permitted.
REQ-019 IDLE: when any req bit is 1, grant by round-robin starting at pointer rr, then go to ISSUE on the next edge.
REQ-020 On grant, latch the grant index and the pair's lag_in slice into eng_lag; eng_lag holds that value until the next grant.
REQ-021 ISSUE: eng_ena=1 on every cycle; the timeout counter increments from 0 each cycle.
REQ-022 ISSUE exit with eng_done=1: latch eng_angle into angle_out and go to RESULT.
REQ-023 ISSUE exit with counter = TIMEOUT-1 and eng_done=0: go to RESULT, flagged as aborted.
REQ-024 If eng_done=1 on the timeout cycle, the job is a success; done takes priority.
REQ-025 RESULT lasts exactly 1 cycle: eng_ena=0 and ack[grant]=1.
REQ-026 RESULT on success: angle_valid=1.
REQ-027 RESULT on abort: timeout_err=1, angle_valid=0, and angle_out is unchanged.
REQ-028 In RESULT, rr becomes (grant+1) mod NUM_PAIRS.
REQ-029 GAP holds eng_ena=0 for GAP cycles, then returns to IDLE; req is ignored during GAP.
REQ-030 eng_done seen outside ISSUE is ignored.
REQ-031 req changes during ISSUE or RESULT do not affect the current job; a pair whose req drops before grant is not served.
REQ-032 The latency from grant to ack is the number of ISSUE cycles + 1; back-to-back jobs are spaced at least GAP+1 idle-engine cycles apart.
REQ-033 With all req bits 1, grants rotate 0,1,2,3,0,...; no pair is granted twice while another pair waits.

Reset
REQ-034 While rst_n=0, the block enters IDLE immediately.
REQ-035 While rst_n=0, all of the following are 0: rr, grant, counters, ack, eng_ena, eng_lag, angle_out, angle_valid, angle_id, busy and timeout_err.
REQ-036 Reset asserted mid-ISSUE abandons the job with no ack, angle_valid or timeout_err.
REQ-037 After reset release, the first grant is evaluated from rr=0.

Verification
REQ-038 Single request: req=0001, lag_in[5:0]=6'sd3, engine answers eng_done with eng_angle=16'd90 after 10 cycles -> eng_lag=3, eng_ena high for 10 cycles, then ack=0001, angle_valid=1, angle_out=90 and angle_id=0 in the same cycle, followed by 2 GAP cycles.
REQ-039 Round-robin: req=1111 held (each pair re-requests after its ack) -> angle_id sequence 0,1,2,3,0 and ack one-hot every job.
REQ-040 Timeout: req=0100, eng_done never asserted -> eng_ena high exactly 64 cycles, then ack=0100, timeout_err=1, angle_id=2, angle_valid=0 and angle_out unchanged.
REQ-041 Done on the final cycle: eng_done=1 on ISSUE cycle 64 -> success path, angle_valid=1, timeout_err=0.
REQ-042 Negative lag and reset: lag_in[11:6]=-6'sd5 on pair 1 gives eng_lag=6'b111011; asserting rst_n=0 during ISSUE then forces all outputs to 0, and after release the next grant starts from pair 0.

Source files
------------

// File: rtl/angle_pair_scheduler.sv
// ---------------------------------------------------------------------------
// angle_pair_scheduler
//
// Shares one angle engine between NUM_PAIRS microphone-pair requesters.
// A round-robin arbiter picks a requesting pair while IDLE. The pair's lag
// is then presented to the engine for up to TIMEOUT cycles (ISSUE). A
// one-cycle RESULT state acknowledges the pair and reports either a fresh
// angle or a timeout. A GAP of idle engine cycles follows before the next
// grant.
//
// Handshake: req[i] is a level request that the pair holds until it sees
// ack[i]. ack is a one-hot pulse, one cycle wide, asserted only in RESULT.
// eng_ena is high on every ISSUE cycle. eng_done is honoured only while
// eng_ena is high, and is ignored in every other state.
//
// Ports
//   clk_60MHz    in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req          in   [NUM_PAIRS]      level request per pair
//   lag_in       in   [6*NUM_PAIRS]    signed lag, pair i at [6i+5:6i]
//   ack          out  [NUM_PAIRS]      one-hot job-close pulse
//   eng_ena      out  engine enable (high throughout ISSUE)
//   eng_lag      out  [6]   lag of the current/last granted pair
//   eng_angle    in   [16]  engine result, valid with eng_done
//   eng_done     in   engine completion pulse
//   angle_out    out  [16]  last successful engine result
//   angle_valid  out  one-cycle pulse on a successful job
//   angle_id     out  [2]   pair index of the last finished job
//   busy         out  high in every state except IDLE
//   timeout_err  out  one-cycle pulse on an aborted job
//   state_dbg    out  [2]   current FSM state (IDLE=0 ISSUE=1 RESULT=2 GAP=3)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module angle_pair_scheduler #(
    parameter int NUM_PAIRS = 4,
    parameter int TIMEOUT   = 64,
    parameter int GAP       = 2
) (
    input  logic                   clk_60MHz,
    input  logic                   rst_n,
    input  logic [NUM_PAIRS-1:0]   req,
    input  logic [6*NUM_PAIRS-1:0] lag_in,
    output logic [NUM_PAIRS-1:0]   ack,
    output logic                   eng_ena,
    output logic [5:0]             eng_lag,
    input  logic [15:0]            eng_angle,
    input  logic                   eng_done,
    output logic [15:0]            angle_out,
    output logic                   angle_valid,
    output logic [1:0]             angle_id,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [1:0]             state_dbg
);

    localparam int GW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [GW-1:0] LAST_PAIR = GW'(NUM_PAIRS - 1);
    localparam logic [TW-1:0] CNT_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RESULT = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [GW-1:0]   rr;          // round-robin search start
    logic [GW-1:0]   grant;       // pair owning the current job
    logic [TW-1:0]   cnt;         // ISSUE cycle counter
    logic [CW-1:0]   gcnt;        // GAP cycle counter
    logic            aborted;     // last ISSUE ended by timeout
    logic            issue_exit;

    logic            pick_found;
    logic [GW-1:0]   pick_idx;

    logic [5:0]      lag_arr [NUM_PAIRS];

    // Split the packed lag bus into one 6-bit slice per pair.
    for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_lag
        assign lag_arr[g] = lag_in[6*g +: 6];
    end

    // Index base+off, wrapped modulo NUM_PAIRS (off is always < NUM_PAIRS).
    function automatic logic [GW-1:0] rr_offset(input logic [GW-1:0] base,
                                                input int            off);
        logic [GW:0] sum;
        sum = {1'b0, base} + (GW+1)'(off);
        if (sum >= (GW+1)'(NUM_PAIRS)) begin
            sum = sum - (GW+1)'(NUM_PAIRS);
        end
        return sum[GW-1:0];
    endfunction

    // Round-robin pick: first requesting pair at or after rr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (!pick_found && req[rr_offset(rr, i)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_offset(rr, i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt   = state;
        ack         = '0;
        eng_ena     = 1'b0;
        angle_valid = 1'b0;
        timeout_err = 1'b0;
        issue_exit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_ena = 1'b1;
                // A done on the final cycle still counts as a success.
                if (eng_done || (cnt == CNT_LAST)) begin
                    issue_exit = 1'b1;
                    state_nxt  = ST_RESULT;
                end
            end
            ST_RESULT: begin
                ack[grant]  = 1'b1;
                angle_valid = !aborted;
                timeout_err = aborted;
                state_nxt   = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Job datapath: grant/lag latch, counters, result capture, rr pointer.
    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            rr        <= '0;
            grant     <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            aborted   <= 1'b0;
            eng_lag   <= '0;
            angle_out <= '0;
            angle_id  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant   <= pick_idx;
                        eng_lag <= lag_arr[pick_idx];
                        cnt     <= '0;
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (issue_exit) begin
                        aborted  <= !eng_done;
                        angle_id <= 2'(grant);
                        if (eng_done) begin
                            angle_out <= eng_angle;
                        end
                    end
                end
                ST_RESULT: begin
                    rr   <= (grant == LAST_PAIR) ? '0 : grant + 1'b1;
                    gcnt <= '0;
                end
                ST_GAP: begin
                    gcnt <= gcnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_angle_pair_scheduler.sv
`timescale 1ns/1ps
module tb_angle_pair_scheduler;

    localparam int NP = 4;
    localparam int TO = 64;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_60MHz = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  req       = '0;
    logic [23:0] lag_in    = '0;
    logic [15:0] eng_angle = '0;
    logic        eng_done  = 1'b0;
    logic [3:0]  ack;
    logic        eng_ena;
    logic [5:0]  eng_lag;
    logic [15:0] angle_out;
    logic        angle_valid;
    logic [1:0]  angle_id;
    logic        busy;
    logic        timeout_err;
    logic [1:0]  state_dbg;

    always #8 clk_60MHz = ~clk_60MHz;

    angle_pair_scheduler #(.NUM_PAIRS(NP), .TIMEOUT(TO), .GAP(2)) dut (
        .clk_60MHz  (clk_60MHz),
        .rst_n      (rst_n),
        .req        (req),
        .lag_in     (lag_in),
        .ack        (ack),
        .eng_ena    (eng_ena),
        .eng_lag    (eng_lag),
        .eng_angle  (eng_angle),
        .eng_done   (eng_done),
        .angle_out  (angle_out),
        .angle_valid(angle_valid),
        .angle_id   (angle_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    int          rr_m = 0;            // model round-robin pointer
    logic [15:0] last_angle = '0;     // model of angle_out

    // ---------------- engine responder ----------------
    int          eng_lat = 0;         // answer on this enabled cycle; 0 = never
    int          eng_cnt = 0;
    logic [15:0] eng_val = '0;
    bit          stray_done = 1'b0;   // pulse done while engine disabled

    initial begin
        forever begin
            @(negedge clk_60MHz);
            if (!rst_n || !eng_ena) begin
                eng_cnt   = 0;
                eng_done  = stray_done && ($urandom_range(0, 1) == 1);
                eng_angle = 16'($urandom);
            end else begin
                eng_cnt   = eng_cnt + 1;
                eng_done  = (eng_lat != 0) && (eng_cnt == eng_lat);
                eng_angle = eng_val;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int model_pick(input int rr, input logic [3:0] r);
        logic [3:0] rv;
        for (int i = 0; i < NP; i++) begin
            rv = r >> ((rr + i) % NP);
            if (rv[0]) return (rr + i) % NP;
        end
        return -1;
    endfunction

    // ---------------- driver / capture tasks ----------------
    task automatic apply_reset();
        @(negedge clk_60MHz);
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk_60MHz);
        rst_n      = 1'b1;
        rr_m       = 0;
        last_angle = '0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_60MHz);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture_job(output bit got, output int ena_n, output logic [5:0] lag_seen,
                               output logic [3:0] a, output logic v, output logic te,
                               output logic [15:0] ang, output logic [1:0] id);
        got = 1'b0; ena_n = 0; lag_seen = '0; a = '0; v = 1'b0; te = 1'b0; ang = '0; id = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_60MHz);
            if (eng_ena) begin
                ena_n    = ena_n + 1;
                lag_seen = eng_lag;
            end
            if (ack != '0) begin
                a = ack; v = angle_valid; te = timeout_err; ang = angle_out; id = angle_id;
                got = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ack !== 4'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_cmp++; if (eng_ena !== 1'b0) begin n_bad++; $display("FAIL reset_eng_ena: got %b want 0", eng_ena); end
        n_cmp++; if (eng_lag !== 6'd0) begin n_bad++; $display("FAIL reset_eng_lag: got %h want 0", eng_lag); end
        n_cmp++; if (angle_out !== 16'd0) begin n_bad++; $display("FAIL reset_angle_out: got %h want 0", angle_out); end
        n_cmp++; if (angle_valid !== 1'b0) begin n_bad++; $display("FAIL reset_angle_valid: got %b want 0", angle_valid); end
        n_cmp++; if (angle_id !== 2'd0) begin n_bad++; $display("FAIL reset_angle_id: got %0d want 0", angle_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0 (IDLE)", state_dbg); end
        repeat (3) @(negedge clk_60MHz);
        rst_n = 1'b1;
        rr_m = 0;
        last_angle = '0;
    endtask

    task automatic test_single();
        bit got; int en; logic [5:0] lg; logic [3:0] a; logic v, te; logic [15:0] ang; logic [1:0] id;
        @(negedge clk_60MHz);
        lag_in       = 24'($urandom);
        lag_in[5:0]  = 6'sd3;
        eng_lat      = 10;
        eng_val      = 16'd90;
        req          = 4'b0001;
        capture_job(got, en, lg, a, v, te, ang, id);
        req = '0;
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL single_ack_seen: got %b want 1", got); end
        n_cmp++; if (en != 10) begin n_bad++; $display("FAIL single_ena_cycles: got %0d want 10", en); end
        n_cmp++; if (lg !== 6'd3) begin n_bad++; $display("FAIL single_eng_lag: got %0d want 3", lg); end
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b want 0001", a); end
        n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", v); end
        n_cmp++; if (te !== 1'b0) begin n_bad++; $display("FAIL single_timeout_err: got %b want 0", te); end
        n_cmp++; if (ang !== 16'd90) begin n_bad++; $display("FAIL single_angle: got %0d want 90", ang); end
        n_cmp++; if (id !== 2'd0) begin n_bad++; $display("FAIL single_id: got %0d want 0", id); end
        rr_m = 1;
        last_angle = 16'd90;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_60MHz);
            n_cmp++;
            if ({busy, eng_ena, ack} !== 6'b10_0000) begin
                n_bad++; $display("FAIL single_gap%0d: got busy=%b ena=%b ack=%b want 1 0 0000", k, busy, eng_ena, ack);
            end
        end
        @(negedge clk_60MHz);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_after_gap: got busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin();
        bit got; int en; logic [5:0] lg; logic [3:0] a; logic v, te; logic [15:0] ang; logic [1:0] id;
        int eid; int lat; logic [3:0] oh; logic [15:0] eang;
        apply_reset();
        lat     = $urandom_range(1, 20);
        eng_lat = lat;
        eng_val = 16'($urandom);
        exp_q.push_back(eng_val);
        req = 4'hF;
        for (int j = 0; j < 5; j++) begin
            eid = model_pick(rr_m, 4'hF);
            oh  = 4'b0001 << eid;
            capture_job(got, en, lg, a, v, te, ang, id);
            eang = exp_q.pop_front();
            n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rr%0d_ack_seen: got %b want 1", j, got); end
            n_cmp++; if (id !== 2'(eid)) begin n_bad++; $display("FAIL rr%0d_id: got %0d want %0d", j, id, eid); end
            n_cmp++; if (a !== oh) begin n_bad++; $display("FAIL rr%0d_ack: got %b want %b", j, a, oh); end
            n_cmp++; if (en != lat) begin n_bad++; $display("FAIL rr%0d_ena_cycles: got %0d want %0d", j, en, lat); end
            n_cmp++; if ({v, ang} !== {1'b1, eang}) begin n_bad++; $display("FAIL rr%0d_result: got v=%b %h want v=1 %h", j, v, ang, eang); end
            rr_m = (eid + 1) % NP;
            last_angle = eang;
            lat     = $urandom_range(1, 20);
            eng_lat = lat;
            eng_val = 16'($urandom);
            exp_q.push_back(eng_val);
        end
        req = '0;
        exp_q.delete();
    endtask

    task automatic test_timeout();
        bit ok; bit got; int en; logic [5:0] lg; logic [3:0] a; logic v, te; logic [15:0] ang; logic [1:0] id;
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL timeout_wait_idle: got busy=%b want 0", busy); end
        eng_lat = 0;
        req     = 4'b0100;
        capture_job(got, en, lg, a, v, te, ang, id);
        req = '0;
        n_cmp++; if (en != TO) begin n_bad++; $display("FAIL timeout_ena_cycles: got %0d want %0d", en, TO); end
        n_cmp++; if (a !== 4'b0100) begin n_bad++; $display("FAIL timeout_ack: got %b want 0100", a); end
        n_cmp++; if (te !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", te); end
        n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL timeout_valid: got %b want 0", v); end
        n_cmp++; if (id !== 2'd2) begin n_bad++; $display("FAIL timeout_id: got %0d want 2", id); end
        n_cmp++; if (ang !== last_angle) begin n_bad++; $display("FAIL timeout_angle_kept: got %h want %h", ang, last_angle); end
        rr_m = 3;
    endtask

    task automatic test_done_last();
        bit ok; bit got; int en; logic [5:0] lg; logic [3:0] a; logic v, te; logic [15:0] ang; logic [1:0] id;
        logic [15:0] val;
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL donelast_wait_idle: got busy=%b want 0", busy); end
        val     = 16'($urandom);
        eng_val = val;
        eng_lat = TO;
        req     = 4'b0001;
        capture_job(got, en, lg, a, v, te, ang, id);
        req = '0;
        n_cmp++; if (en != TO) begin n_bad++; $display("FAIL donelast_ena_cycles: got %0d want %0d", en, TO); end
        n_cmp++; if ({v, te} !== 2'b10) begin n_bad++; $display("FAIL donelast_flags: got v=%b te=%b want v=1 te=0", v, te); end
        n_cmp++; if (ang !== val) begin n_bad++; $display("FAIL donelast_angle: got %h want %h", ang, val); end
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL donelast_ack: got %b want 0001", a); end
        rr_m = 1;
        last_angle = val;
    endtask

    task automatic test_random();
        bit ok; bit got; int en; logic [5:0] lg; logic [3:0] a; logic v, te; logic [15:0] ang; logic [1:0] id;
        logic [3:0] r; int eid; int lat; logic [15:0] val; logic [5:0] elag; logic [23:0] sh;
        logic [3:0] oh; bit succ; int een; logic [15:0] eang;
        stray_done = 1'b1;
        for (int j = 0; j < 25; j++) begin
            wait_idle(ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rand%0d_wait_idle: got busy=%b want 0", j, busy); end
            r       = 4'($urandom_range(1, 15));
            lag_in  = 24'($urandom);
            lat     = $urandom_range(1, 80);
            val     = 16'($urandom);
            eng_lat = lat;
            eng_val = val;
            req     = r;
            eid  = model_pick(rr_m, r);
            sh   = lag_in >> (6 * eid);
            elag = sh[5:0];
            oh   = 4'b0001 << eid;
            succ = (lat <= TO);
            een  = succ ? lat : TO;
            eang = succ ? val : last_angle;
            capture_job(got, en, lg, a, v, te, ang, id);
            req = '0;
            n_cmp++; if (a !== oh) begin n_bad++; $display("FAIL rand%0d_ack: got %b want %b (req %b)", j, a, oh, r); end
            n_cmp++; if (id !== 2'(eid)) begin n_bad++; $display("FAIL rand%0d_id: got %0d want %0d", j, id, eid); end
            n_cmp++; if (lg !== elag) begin n_bad++; $display("FAIL rand%0d_lag: got %h want %h", j, lg, elag); end
            n_cmp++; if (en != een) begin n_bad++; $display("FAIL rand%0d_ena_cycles: got %0d want %0d", j, en, een); end
            n_cmp++; if ({v, te} !== {succ, !succ}) begin n_bad++; $display("FAIL rand%0d_flags: got v=%b te=%b want v=%b te=%b", j, v, te, succ, !succ); end
            n_cmp++; if (ang !== eang) begin n_bad++; $display("FAIL rand%0d_angle: got %h want %h", j, ang, eang); end
            rr_m = (eid + 1) % NP;
            last_angle = eang;
        end
        stray_done = 1'b0;
    endtask

    task automatic test_neg_lag_reset();
        bit ok; bit got; int en; logic [5:0] lg; logic [3:0] a; logic v, te; logic [15:0] ang; logic [1:0] id;
        int seen; logic [15:0] val;
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL neglag_wait_idle: got busy=%b want 0", busy); end
        lag_in        = 24'($urandom);
        lag_in[11:6]  = -6'sd5;
        eng_lat       = 0;
        req           = 4'b0010;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_60MHz);
            if (eng_ena) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL neglag_issue_start: got ena=%b want 1", eng_ena); end
        repeat (5) @(negedge clk_60MHz);
        n_cmp++; if (eng_lag !== 6'b111011) begin n_bad++; $display("FAIL neglag_eng_lag: got %b want 111011", eng_lag); end
        rst_n = 1'b0;
        req   = '0;
        #1;
        n_cmp++;
        if ({ack, eng_ena, eng_lag, angle_out, angle_valid, angle_id, busy, timeout_err} !== 32'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got ack=%b ena=%b lag=%h ang=%h v=%b id=%0d busy=%b te=%b want all 0",
                     ack, eng_ena, eng_lag, angle_out, angle_valid, angle_id, busy, timeout_err);
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_60MHz);
            if (ack != '0 || angle_valid || timeout_err) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midreset_no_close: got %0d closing cycles want 0", seen); end
        rst_n      = 1'b1;
        rr_m       = 0;
        last_angle = '0;
        val        = 16'($urandom);
        eng_val    = val;
        eng_lat    = 5;
        req        = 4'b1111;
        capture_job(got, en, lg, a, v, te, ang, id);
        req = '0;
        n_cmp++; if (id !== 2'(model_pick(rr_m, 4'b1111))) begin n_bad++; $display("FAIL postreset_first_id: got %0d want 0", id); end
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL postreset_ack: got %b want 0001", a); end
        n_cmp++; if ({v, ang} !== {1'b1, val}) begin n_bad++; $display("FAIL postreset_result: got v=%b %h want v=1 %h", v, ang, val); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_last();
        test_random();
        test_neg_lag_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
